// File: rtl/vend_sequencer_if.sv
// Coin-slot, dispenser and hopper signals of the vend sequencer.
// master = the sequencer itself, slave = the front end and actuators around it.
interface vend_sequencer_if #(
    parameter int unsigned CREDIT_W = 6
);
    logic                nickel_i;
    logic                dime_i;
    logic                quarter_i;
    logic                cancel_i;
    logic                vend_ack_i;
    logic                change_ack_i;
    logic                coin_accept_o;
    logic                vend_req_o;
    logic                change_req_o;
    logic                soda_o;
    logic                reject_o;
    logic                busy_o;
    logic [CREDIT_W-1:0] credit_o;
    logic [2:0]          change_o;

    modport master (
        input  nickel_i, dime_i, quarter_i, cancel_i, vend_ack_i, change_ack_i,
        output coin_accept_o, vend_req_o, change_req_o, soda_o, reject_o, busy_o,
               credit_o, change_o
    );

    modport slave (
        output nickel_i, dime_i, quarter_i, cancel_i, vend_ack_i, change_ack_i,
        input  coin_accept_o, vend_req_o, change_req_o, soda_o, reject_o, busy_o,
               credit_o, change_o
    );
endinterface

// File: rtl/vend_sequencer.sv
// Coin/soda control sequencer: accumulates credit, runs the dispenser req/ack handshake and
// returns change or refunds one nickel per hopper ack.
module vend_sequencer #(
    parameter int unsigned PRICE       = 20,
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    vend_sequencer_if.master bus
);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StVend    = 2'd2;
    localparam logic [1:0] StChange  = 2'd3;

    localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TimerW-1:0]   TimerLast = TimerW'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W-1:0] PriceVal  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] Nickel    = CREDIT_W'(5);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          change_q, change_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                soda_q, soda_d;
    logic                reject_q, reject_d;

    logic                coin_any;
    logic                coin_multi;
    logic                accepting;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] credit_sum;

    assign coin_any   = bus.nickel_i | bus.dime_i | bus.quarter_i;
    assign coin_multi = (bus.nickel_i & bus.dime_i) | (bus.nickel_i & bus.quarter_i) |
                        (bus.dime_i & bus.quarter_i);
    assign accepting  = (state_q == StIdle) || (state_q == StCollect);
    assign credit_sum = credit_q + coin_val;

    always_comb begin
        coin_val = '0;
        if (bus.quarter_i) begin
            coin_val = CREDIT_W'(25);
        end else if (bus.dime_i) begin
            coin_val = CREDIT_W'(10);
        end else if (bus.nickel_i) begin
            coin_val = Nickel;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        timer_d  = timer_q;
        soda_d   = 1'b0;
        // Losers of a multi-coin cycle and coins offered while the slot is shut are dropped.
        reject_d = coin_any & (coin_multi | ~accepting);

        case (state_q)
            StIdle: begin
                if (coin_any) begin
                    change_d = '0;
                    credit_d = coin_val;
                    timer_d  = '0;
                    state_d  = (coin_val >= PriceVal) ? StVend : StCollect;
                end
            end
            StCollect: begin
                if (coin_any) begin
                    credit_d = credit_sum;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (bus.cancel_i || (!coin_any && timer_q == TimerLast)) begin
                    state_d = StChange;
                    timer_d = '0;
                end else if (coin_any && credit_sum >= PriceVal) begin
                    state_d = StVend;
                    timer_d = '0;
                end
            end
            StVend: begin
                if (bus.vend_ack_i) begin
                    credit_d = credit_q - PriceVal;
                    soda_d   = 1'b1;
                    state_d  = (credit_q != PriceVal) ? StChange : StIdle;
                end
            end
            default: begin
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else if (bus.change_ack_i) begin
                    credit_d = credit_q - Nickel;
                    if (change_q != 3'd7) begin
                        change_d = change_q + 1'b1;
                    end
                    if (credit_q == Nickel) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            credit_q <= '0;
            change_q <= '0;
            timer_q  <= '0;
            soda_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            timer_q  <= timer_d;
            soda_q   <= soda_d;
            reject_q <= reject_d;
        end
    end

    assign bus.coin_accept_o = accepting;
    assign bus.vend_req_o    = (state_q == StVend);
    assign bus.change_req_o  = (state_q == StChange) && (credit_q != '0);
    assign bus.soda_o        = soda_q;
    assign bus.reject_o      = reject_q;
    assign bus.busy_o        = (state_q != StIdle);
    assign bus.credit_o      = credit_q;
    assign bus.change_o      = change_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: one task per scenario, expected values worked out by hand.
module tb_vend_sequencer;
    localparam int unsigned Timeout = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   failed   = 0;

    vend_sequencer_if #(.CREDIT_W(6)) bus ();

    vend_sequencer #(
        .PRICE      (20),
        .CREDIT_W   (6),
        .TIMEOUT_CYC(Timeout)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        compared++; if (bus.coin_accept_o !== 1'b1) begin failed++; $display("FAIL rst_accept: got %b want 1", bus.coin_accept_o); end
        compared++; if (bus.busy_o !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
        compared++; if (bus.credit_o !== 6'd0) begin failed++; $display("FAIL rst_credit: got %0d want 0", bus.credit_o); end
        compared++; if (bus.change_o !== 3'd0) begin failed++; $display("FAIL rst_change: got %0d want 0", bus.change_o); end
        compared++; if ({bus.vend_req_o, bus.change_req_o, bus.soda_o, bus.reject_o} !== 4'b0) begin
            failed++; $display("FAIL rst_outs: got %b want 0000",
                               {bus.vend_req_o, bus.change_req_o, bus.soda_o, bus.reject_o});
        end
        rst = 1'b0;
    endtask

    task automatic test_exact_price();
        bus.dime_i = 1'b1; tick(); bus.dime_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd10) begin failed++; $display("FAIL t1_credit10: got %0d want 10", bus.credit_o); end
        compared++; if (bus.vend_req_o !== 1'b0) begin failed++; $display("FAIL t1_noreq: got %b want 0", bus.vend_req_o); end
        tick();
        bus.dime_i = 1'b1; tick(); bus.dime_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd20) begin failed++; $display("FAIL t1_credit20: got %0d want 20", bus.credit_o); end
        compared++; if (bus.vend_req_o !== 1'b1) begin failed++; $display("FAIL t1_req: got %b want 1", bus.vend_req_o); end
        compared++; if (bus.coin_accept_o !== 1'b0) begin failed++; $display("FAIL t1_slot: got %b want 0", bus.coin_accept_o); end
        repeat (2) tick();
        compared++; if (bus.vend_req_o !== 1'b1) begin failed++; $display("FAIL t1_req_held: got %b want 1", bus.vend_req_o); end
        bus.vend_ack_i = 1'b1; tick(); bus.vend_ack_i = 1'b0;
        compared++; if (bus.soda_o !== 1'b1) begin failed++; $display("FAIL t1_soda: got %b want 1", bus.soda_o); end
        compared++; if (bus.credit_o !== 6'd0) begin failed++; $display("FAIL t1_credit0: got %0d want 0", bus.credit_o); end
        compared++; if (bus.busy_o !== 1'b0) begin failed++; $display("FAIL t1_idle: got %b want 0", bus.busy_o); end
        compared++; if (bus.change_o !== 3'd0) begin failed++; $display("FAIL t1_change: got %0d want 0", bus.change_o); end
        tick();
        compared++; if (bus.soda_o !== 1'b0) begin failed++; $display("FAIL t1_soda_pulse: got %b want 0", bus.soda_o); end
    endtask

    task automatic test_quarter_change();
        bus.quarter_i = 1'b1; tick(); bus.quarter_i = 1'b0;
        compared++; if (bus.vend_req_o !== 1'b1) begin failed++; $display("FAIL t2_req: got %b want 1", bus.vend_req_o); end
        bus.vend_ack_i = 1'b1; tick(); bus.vend_ack_i = 1'b0;
        compared++; if (bus.change_req_o !== 1'b1) begin failed++; $display("FAIL t2_chreq: got %b want 1", bus.change_req_o); end
        compared++; if (bus.credit_o !== 6'd5) begin failed++; $display("FAIL t2_credit5: got %0d want 5", bus.credit_o); end
        bus.change_ack_i = 1'b1; tick(); bus.change_ack_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd0) begin failed++; $display("FAIL t2_credit0: got %0d want 0", bus.credit_o); end
        compared++; if (bus.change_o !== 3'd1) begin failed++; $display("FAIL t2_change: got %0d want 1", bus.change_o); end
        compared++; if (bus.busy_o !== 1'b0 || bus.change_req_o !== 1'b0) begin
            failed++; $display("FAIL t2_idle: got busy=%b chreq=%b want 0 0", bus.busy_o, bus.change_req_o);
        end
    endtask

    task automatic test_cancel();
        logic [5:0] exp_credit;
        bus.nickel_i = 1'b1; tick(); bus.nickel_i = 1'b0;
        bus.dime_i = 1'b1; tick(); bus.dime_i = 1'b0;
        bus.cancel_i = 1'b1; tick(); bus.cancel_i = 1'b0;
        compared++; if (bus.change_req_o !== 1'b1 || bus.vend_req_o !== 1'b0) begin
            failed++; $display("FAIL t3_state: got chreq=%b vreq=%b want 1 0", bus.change_req_o, bus.vend_req_o);
        end
        compared++; if (bus.credit_o !== 6'd15) begin failed++; $display("FAIL t3_credit: got %0d want 15", bus.credit_o); end
        exp_credit = 6'd15;
        for (int i = 0; i < 3; i++) begin
            repeat (2) tick();
            compared++; if (bus.credit_o !== exp_credit) begin failed++; $display("FAIL t3_gap%0d: got %0d want %0d", i, bus.credit_o, exp_credit); end
            bus.change_ack_i = 1'b1; tick(); bus.change_ack_i = 1'b0;
            exp_credit = exp_credit - 6'd5;
            compared++; if (bus.credit_o !== exp_credit) begin failed++; $display("FAIL t3_ack%0d: got %0d want %0d", i, bus.credit_o, exp_credit); end
        end
        compared++; if (bus.change_o !== 3'd3) begin failed++; $display("FAIL t3_change: got %0d want 3", bus.change_o); end
        compared++; if (bus.busy_o !== 1'b0) begin failed++; $display("FAIL t3_idle: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_timeout();
        int soda_seen = 0;
        bus.nickel_i = 1'b1; tick(); bus.nickel_i = 1'b0;
        for (int i = 0; i < int'(Timeout) - 1; i++) begin
            tick();
            if (bus.soda_o === 1'b1) soda_seen++;
        end
        compared++; if (bus.change_req_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failed++; $display("FAIL t4_early: got chreq=%b busy=%b want 0 1", bus.change_req_o, bus.busy_o);
        end
        tick();
        compared++; if (bus.change_req_o !== 1'b1) begin failed++; $display("FAIL t4_refund: got %b want 1", bus.change_req_o); end
        compared++; if (bus.credit_o !== 6'd5) begin failed++; $display("FAIL t4_credit: got %0d want 5", bus.credit_o); end
        bus.change_ack_i = 1'b1; tick(); bus.change_ack_i = 1'b0;
        if (bus.soda_o === 1'b1) soda_seen++;
        compared++; if (bus.change_o !== 3'd1 || bus.busy_o !== 1'b0) begin
            failed++; $display("FAIL t4_done: got change=%0d busy=%b want 1 0", bus.change_o, bus.busy_o);
        end
        compared++; if (soda_seen !== 0) begin failed++; $display("FAIL t4_nosoda: got %0d pulses want 0", soda_seen); end
    endtask

    task automatic test_reject();
        bus.nickel_i = 1'b1; bus.quarter_i = 1'b1; tick(); bus.nickel_i = 1'b0; bus.quarter_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd25) begin failed++; $display("FAIL t5_credit: got %0d want 25", bus.credit_o); end
        compared++; if (bus.reject_o !== 1'b1) begin failed++; $display("FAIL t5_rej_multi: got %b want 1", bus.reject_o); end
        bus.dime_i = 1'b1; tick(); bus.dime_i = 1'b0;
        compared++; if (bus.reject_o !== 1'b1) begin failed++; $display("FAIL t5_rej_vend: got %b want 1", bus.reject_o); end
        compared++; if (bus.credit_o !== 6'd25) begin failed++; $display("FAIL t5_hold: got %0d want 25", bus.credit_o); end
        tick();
        compared++; if (bus.reject_o !== 1'b0) begin failed++; $display("FAIL t5_rej_pulse: got %b want 0", bus.reject_o); end
        bus.vend_ack_i = 1'b1; tick(); bus.vend_ack_i = 1'b0;
        bus.change_ack_i = 1'b1; tick(); bus.change_ack_i = 1'b0;
        compared++; if (bus.busy_o !== 1'b0) begin failed++; $display("FAIL t5_idle: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_back_to_back();
        bus.nickel_i = 1'b1; tick(); bus.nickel_i = 1'b0;
        bus.dime_i = 1'b1; tick(); bus.dime_i = 1'b0;
        bus.quarter_i = 1'b1; tick(); bus.quarter_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd40 || bus.vend_req_o !== 1'b1) begin
            failed++; $display("FAIL t7_credit40: got %0d req=%b want 40 1", bus.credit_o, bus.vend_req_o);
        end
        bus.vend_ack_i = 1'b1; tick(); bus.vend_ack_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd20) begin failed++; $display("FAIL t7_rem: got %0d want 20", bus.credit_o); end
        bus.change_ack_i = 1'b1;
        repeat (4) tick();
        compared++; if (bus.credit_o !== 6'd0 || bus.change_o !== 3'd4 || bus.busy_o !== 1'b0) begin
            failed++; $display("FAIL t7_b2b: got credit=%0d change=%0d busy=%b want 0 4 0",
                               bus.credit_o, bus.change_o, bus.busy_o);
        end
        tick();
        bus.change_ack_i = 1'b0;
        compared++; if (bus.change_o !== 3'd4 || bus.credit_o !== 6'd0) begin
            failed++; $display("FAIL t7_stray_ack: got change=%0d credit=%0d want 4 0", bus.change_o, bus.credit_o);
        end
    endtask

    task automatic test_reset_mid_change();
        bus.dime_i = 1'b1; tick(); bus.dime_i = 1'b0;
        bus.nickel_i = 1'b1; bus.cancel_i = 1'b1; tick(); bus.nickel_i = 1'b0; bus.cancel_i = 1'b0;
        bus.change_ack_i = 1'b1; tick(); bus.change_ack_i = 1'b0;
        compared++; if (bus.credit_o !== 6'd10 || bus.change_req_o !== 1'b1) begin
            failed++; $display("FAIL t6_pre: got credit=%0d chreq=%b want 10 1", bus.credit_o, bus.change_req_o);
        end
        #2 rst = 1'b1;
        #1;
        compared++; if (bus.busy_o !== 1'b0 || bus.coin_accept_o !== 1'b1) begin
            failed++; $display("FAIL t6_idle: got busy=%b accept=%b want 0 1", bus.busy_o, bus.coin_accept_o);
        end
        compared++; if (bus.credit_o !== 6'd0 || bus.change_req_o !== 1'b0 || bus.change_o !== 3'd0) begin
            failed++; $display("FAIL t6_clear: got credit=%0d chreq=%b change=%0d want 0 0 0",
                               bus.credit_o, bus.change_req_o, bus.change_o);
        end
        tick();
        rst = 1'b0;
        tick();
        compared++; if (bus.change_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failed++; $display("FAIL t6_norefund: got chreq=%b busy=%b want 0 0", bus.change_req_o, bus.busy_o);
        end
    endtask

    initial begin
        bus.nickel_i     = 1'b0;
        bus.dime_i       = 1'b0;
        bus.quarter_i    = 1'b0;
        bus.cancel_i     = 1'b0;
        bus.vend_ack_i   = 1'b0;
        bus.change_ack_i = 1'b0;
        test_reset();
        test_exact_price();
        test_quarter_change();
        test_cancel();
        test_timeout();
        test_reject();
        test_back_to_back();
        test_reset_mid_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
